coreuart_tx_fifo_reader: RTL and testbench

//  Read-side engine for the 256x8 UART TX FIFO: pops bytes, serializes them onto TX as 8N1/7N1 with optional parity.

---
 rtl/coreuart_tx_fifo_reader_pkg.sv | 27 ++
 rtl/coreuart_tx_baud_tick.sv | 27 ++
 rtl/coreuart_tx_fifo_reader.sv | 191 +++++++++++++++++++
 tb/tb_coreuart_tx_fifo_reader.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coreuart_tx_fifo_reader_pkg.sv
// Shared definitions for the UART TX FIFO read-side engine: FSM states,
// oversampling constants and the frame parity helper.
package coreuart_tx_fifo_reader_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int OS_W       = $clog2(OVERSAMPLE);
    localparam int DATA_MAX   = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_t;

    // In 7-bit mode DO[7] must not contribute to parity.
    function automatic logic frame_parity(input logic [7:0] data,
                                          input logic       bit8,
                                          input logic       odd_n_even);
        logic [7:0] used;
        used = bit8 ? data : {1'b0, data[6:0]};
        return (^used) ^ odd_n_even;
    endfunction

endpackage

// File: rtl/coreuart_tx_baud_tick.sv
// 16x baud tick generator: down-counter reloading from baud_val, tick when it hits zero.
// A new baud_val is picked up only at the next reload; clear restarts the phase.
module coreuart_tx_baud_tick #(
    parameter int BAUD_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [BAUD_W-1:0] baud_val,
    output logic              tick
);

    logic [BAUD_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear || (count == '0)) begin
            count <= baud_val;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/coreuart_tx_fifo_reader.sv
// Read-side engine of the UART TX FIFO: pops bytes and serializes them as 8N1/7N1 (+parity).
// Define COREUART_TX_STOP2_EN to add the STOP2 input for two stop bits.
module coreuart_tx_fifo_reader
    import coreuart_tx_fifo_reader_pkg::*;
#(
    parameter int BAUD_W     = 13,
    parameter int RD_LATENCY = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [BAUD_W-1:0] BAUD_VAL,
    input  logic              BIT8,
    input  logic              PARITY_EN,
    input  logic              ODD_N_EVEN,
`ifdef COREUART_TX_STOP2_EN
    input  logic              STOP2,
`endif
    input  logic              FIFO_EMPTY,
    input  logic [7:0]        FIFO_DO,
    output logic              FIFO_RDB,
    output logic              TX,
    output logic              TX_BUSY
);

    localparam int FETCH_W = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);

    tx_state_t          state, state_next;
    logic               tick;
    logic               bit_done;
    logic               load_frame;
    logic               tx_next;
    logic               rdb_next;
    logic               busy_next;
    logic [OS_W-1:0]    os_cnt;
    logic [2:0]         bit_cnt;
    logic [2:0]         last_bit;
    logic [FETCH_W-1:0] fetch_cnt;
    logic [7:0]         shift_reg;
    logic               parity_bit;
    logic               bit8_q;
    logic               parity_en_q;
    logic               stop_cnt;
    logic               stop_last;

    coreuart_tx_baud_tick #(
        .BAUD_W (BAUD_W)
    ) u_baud_tick (
        .clk      (CLK),
        .reset    (RESET),
        .clear    (load_frame),
        .baud_val (BAUD_VAL),
        .tick     (tick)
    );

    assign bit_done = tick && (os_cnt == OS_W'(OVERSAMPLE - 1));
    assign last_bit = bit8_q ? 3'(DATA_MAX - 1) : 3'(DATA_MAX - 2);

`ifdef COREUART_TX_STOP2_EN
    logic stop2_q;
    assign stop_last = stop2_q;
`else
    assign stop_last = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_IDLE;
            TX       <= 1'b1;
            FIFO_RDB <= 1'b0;
            TX_BUSY  <= 1'b0;
        end else begin
            state    <= state_next;
            TX       <= tx_next;
            FIFO_RDB <= rdb_next;
            TX_BUSY  <= busy_next;
        end
    end

    // TX is registered: each branch presents the level of the bit about to begin.
    always_comb begin
        state_next = state;
        tx_next    = TX;
        rdb_next   = 1'b0;
        busy_next  = TX_BUSY;
        load_frame = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
                if (!FIFO_EMPTY) begin
                    rdb_next   = 1'b1;
                    busy_next  = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (fetch_cnt == FETCH_W'(RD_LATENCY)) begin
                    load_frame = 1'b1;
                    tx_next    = 1'b0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    tx_next    = shift_reg[0];
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_cnt == last_bit) begin
                        if (parity_en_q) begin
                            tx_next    = parity_bit;
                            state_next = ST_PARITY;
                        end else begin
                            tx_next    = 1'b1;
                            state_next = ST_STOP;
                        end
                    end else begin
                        tx_next = shift_reg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    tx_next    = 1'b1;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done && (stop_cnt == stop_last)) begin
                    if (!FIFO_EMPTY) begin
                        rdb_next   = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        busy_next  = 1'b0;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                tx_next    = 1'b1;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Frame settings are captured with the byte so mid-frame changes wait for the next one.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_cnt   <= '0;
            os_cnt      <= '0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            shift_reg   <= '0;
            parity_bit  <= 1'b0;
            bit8_q      <= 1'b0;
            parity_en_q <= 1'b0;
`ifdef COREUART_TX_STOP2_EN
            stop2_q     <= 1'b0;
`endif
        end else begin
            fetch_cnt <= (state == ST_FETCH) ? fetch_cnt + 1'b1 : '0;
            if (load_frame) begin
                os_cnt      <= '0;
                bit_cnt     <= '0;
                stop_cnt    <= 1'b0;
                shift_reg   <= BIT8 ? FIFO_DO : {1'b0, FIFO_DO[6:0]};
                parity_bit  <= frame_parity(FIFO_DO, BIT8, ODD_N_EVEN);
                bit8_q      <= BIT8;
                parity_en_q <= PARITY_EN;
`ifdef COREUART_TX_STOP2_EN
                stop2_q     <= STOP2;
`endif
            end else begin
                if (tick) begin
                    os_cnt <= os_cnt + 1'b1;
                end
                if (bit_done && (state == ST_DATA)) begin
                    shift_reg <= shift_reg >> 1;
                    bit_cnt   <= bit_cnt + 1'b1;
                end
                if (bit_done && (state == ST_STOP)) begin
                    stop_cnt <= ~stop_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_coreuart_tx_fifo_reader.sv
// Self-checking bench for coreuart_tx_fifo_reader: FIFO model with registered read data
// plus a bit-level scoreboard of expected TX frames.
module tb_coreuart_tx_fifo_reader;

    localparam int BAUD_W     = 13;
    localparam int RD_LATENCY = 2;

    logic              clk        = 1'b0;
    logic              reset      = 1'b1;
    logic [BAUD_W-1:0] baud_val   = '0;
    logic              bit8       = 1'b1;
    logic              parity_en  = 1'b0;
    logic              odd_n_even = 1'b0;
`ifdef COREUART_TX_STOP2_EN
    logic              stop2      = 1'b0;
`endif
    logic              fifo_empty = 1'b1;
    logic [7:0]        fifo_do    = '0;
    logic              fifo_rdb;
    logic              tx;
    logic              tx_busy;

    logic [7:0] fifo_q[$];
    logic [7:0] fifo_stage = '0;
    logic       hold_empty = 1'b0;
    int         rd_count = 0;
    int         underflow_count = 0;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    bit         exp_bit_q[$];
    int         len_q[$];

    coreuart_tx_fifo_reader #(
        .BAUD_W     (BAUD_W),
        .RD_LATENCY (RD_LATENCY)
    ) dut (
        .CLK        (clk),
        .RESET      (reset),
        .BAUD_VAL   (baud_val),
        .BIT8       (bit8),
        .PARITY_EN  (parity_en),
        .ODD_N_EVEN (odd_n_even),
`ifdef COREUART_TX_STOP2_EN
        .STOP2      (stop2),
`endif
        .FIFO_EMPTY (fifo_empty),
        .FIFO_DO    (fifo_do),
        .FIFO_RDB   (fifo_rdb),
        .TX         (tx),
        .TX_BUSY    (tx_busy)
    );

    always #5 clk = ~clk;

    // FIFO read side: array read then output register, so DO is valid two edges after RDB asserts.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rdb === 1'b1) begin
            rd_count <= rd_count + 1;
            if (fifo_q.size() == 0) begin
                underflow_count <= underflow_count + 1;
            end else begin
                fifo_stage <= fifo_q.pop_front();
            end
        end
        fifo_do    <= fifo_stage;
        fifo_empty <= hold_empty || (fifo_q.size() == 0);
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sb_push_frame(input logic [7:0] b, input logic b8, input logic pen,
                                 input logic odd, input int nstop);
        int n;
        int ones;
        n = 0;
        ones = 0;
        exp_bit_q.push_back(1'b0);
        n++;
        for (int i = 0; i < (b8 ? 8 : 7); i++) begin
            exp_bit_q.push_back(b[i]);
            if (b[i]) ones++;
            n++;
        end
        if (pen) begin
            exp_bit_q.push_back(((ones % 2) == 1) ^ odd);
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            exp_bit_q.push_back(1'b1);
            n++;
        end
        len_q.push_back(n);
    endtask

    task automatic wait_rdb(input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (fifo_rdb === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (tx_busy === 1'b0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: got busy=%b want 0", tx_busy);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_frames(input int nframes, input int period,
                                output int first_rdb, output int last_rdb);
        int   prev_rdb;
        int   prev_bits;
        int   nbits;
        int   c;
        int   bit_i;
        bit   exp;
        logic ok;
        prev_rdb  = 0;
        prev_bits = 0;
        first_rdb = -1;
        last_rdb  = -1;
        for (int f = 0; f < nframes; f++) begin
            nbits = len_q.pop_front();
            wait_rdb(5000, ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("[TB] FAIL rdb_timeout: frame %0d got no FIFO_RDB want pulse", f);
                exp_bit_q.delete();
                len_q.delete();
                return;
            end
            if (f == 0) begin
                first_rdb = cyc;
            end else begin
                checks++;
                if ((cyc - prev_rdb) !== (RD_LATENCY + 1 + prev_bits * period)) begin
                    errors++;
                    $display("[TB] FAIL frame_spacing: got %0d clks want %0d", cyc - prev_rdb,
                             RD_LATENCY + 1 + prev_bits * period);
                end
            end
            prev_rdb  = cyc;
            prev_bits = nbits;
            bit_i     = 0;
            c         = 0;
            while (bit_i < nbits) begin
                @(negedge clk);
                c++;
                if (c == 1) begin
                    checks++;
                    if (fifo_rdb !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL rdb_pulse: got %b want 0 one clk after strobe", fifo_rdb);
                    end
                end
                if (c == RD_LATENCY) begin
                    checks++;
                    if (tx !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL start_pre: got %b want 1", tx);
                    end
                end
                if (c == RD_LATENCY + 1) begin
                    checks++;
                    if (tx !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL start_edge: got %b want 0", tx);
                    end
                end
                if (c == RD_LATENCY + 1 + period * bit_i + period / 2) begin
                    exp = exp_bit_q.pop_front();
                    checks++;
                    if (tx !== exp) begin
                        errors++;
                        $display("[TB] FAIL frame_bit: frame %0d bit %0d got %b want %b", f, bit_i, tx, exp);
                    end
                    bit_i++;
                end
            end
        end
        last_rdb = prev_rdb;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b want 1", tx); end
        checks++;
        if (fifo_rdb !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdb: got %b want 0", fifo_rdb); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", tx_busy); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic_8n1();
        int first_rdb;
        int last_rdb;
        int fall;
        int rd_before;
        $display("[TB] 8N1 frame 0xA5 at BAUD_VAL=0");
        baud_val  = '0;
        bit8      = 1'b1;
        parity_en = 1'b0;
        rd_before = rd_count;
        sb_push_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1);
        fifo_q.push_back(8'hA5);
        check_frames(1, 16, first_rdb, last_rdb);
        fall = -1;
        for (int i = 0; i < 64 && fall < 0; i++) begin
            @(negedge clk);
            if (tx_busy === 1'b0) fall = cyc;
        end
        checks++;
        if ((fall - first_rdb) !== (160 + RD_LATENCY + 1)) begin
            errors++;
            $display("[TB] FAIL busy_length: got %0d clks want %0d", fall - first_rdb, 160 + RD_LATENCY + 1);
        end
        checks++;
        if ((rd_count - rd_before) !== 1) begin
            errors++;
            $display("[TB] FAIL basic_reads: got %0d want 1", rd_count - rd_before);
        end
        wait_idle();
    endtask

    task automatic test_7bit_parity();
        int   first_rdb;
        int   last_rdb;
        logic ok;
        $display("[TB] 7-bit odd parity 0xC1 at BAUD_VAL=3");
        baud_val   = 13'd3;
        bit8       = 1'b0;
        parity_en  = 1'b1;
        odd_n_even = 1'b1;
        sb_push_frame(8'hC1, 1'b0, 1'b1, 1'b1, 1);
        fifo_q.push_back(8'hC1);
        fork
            check_frames(1, 64, first_rdb, last_rdb);
            begin
                wait_rdb(5000, ok);
                repeat (100) @(negedge clk);
                bit8       = 1'b1;
                odd_n_even = 1'b0;
            end
        join
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int first_rdb;
        int last_rdb;
        int rd_before;
        int uf_before;
        $display("[TB] back-to-back 0x00 0xFF 0x55");
        baud_val   = '0;
        bit8       = 1'b1;
        parity_en  = 1'b0;
        odd_n_even = 1'b0;
        rd_before  = rd_count;
        uf_before  = underflow_count;
        sb_push_frame(8'h00, 1'b1, 1'b0, 1'b0, 1);
        sb_push_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1);
        sb_push_frame(8'h55, 1'b1, 1'b0, 1'b0, 1);
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        fifo_q.push_back(8'h55);
        check_frames(3, 16, first_rdb, last_rdb);
        wait_idle();
        checks++;
        if ((rd_count - rd_before) !== 3) begin
            errors++;
            $display("[TB] FAIL b2b_reads: got %0d want 3", rd_count - rd_before);
        end
        checks++;
        if (underflow_count !== uf_before) begin
            errors++;
            $display("[TB] FAIL b2b_underflow: got %0d want %0d", underflow_count, uf_before);
        end
    endtask

    task automatic test_empty_in_stop();
        int   first_rdb;
        int   last_rdb;
        logic ok;
        $display("[TB] FIFO refilled during stop bit");
        sb_push_frame(8'h96, 1'b1, 1'b0, 1'b0, 1);
        sb_push_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1);
        fifo_q.push_back(8'h96);
        fork
            check_frames(2, 16, first_rdb, last_rdb);
            begin
                wait_rdb(5000, ok);
                repeat (RD_LATENCY + 1 + 16 * 9 + 4) @(negedge clk);
                fifo_q.push_back(8'h3C);
            end
        join
        wait_idle();
    endtask

    task automatic test_empty_stuck();
        int rd_before;
        int bad;
        $display("[TB] FIFO_EMPTY held high with data present");
        hold_empty = 1'b1;
        fifo_q.push_back(8'h5A);
        rd_before = rd_count;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_rdb !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("[TB] FAIL stuck_line: got %0d active clks want 0", bad); end
        checks++;
        if (rd_count !== rd_before) begin
            errors++;
            $display("[TB] FAIL stuck_reads: got %0d want %0d", rd_count, rd_before);
        end
        fifo_q.delete();
        hold_empty = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        logic ok;
        int   rd_before;
        int   bad;
        $display("[TB] reset in the middle of a data bit");
        baud_val = '0;
        bit8     = 1'b1;
        fifo_q.push_back(8'h00);
        wait_rdb(5000, ok);
        repeat (RD_LATENCY + 1 + 16 * 2 + 8) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("[TB] FAIL midframe_tx: got %b want 0", tx); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("[TB] FAIL rst_tx: got %b want 1", tx); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b want 0", tx_busy); end
        rd_before = rd_count;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_rdb !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("[TB] FAIL rst_quiet: got %0d active clks want 0", bad); end
        checks++;
        if (rd_count !== rd_before) begin
            errors++;
            $display("[TB] FAIL rst_reads: got %0d want %0d", rd_count, rd_before);
        end
    endtask

`ifdef COREUART_TX_STOP2_EN
    task automatic test_stop2();
        int   first_rdb;
        int   last_rdb;
        logic ok;
        $display("[TB] two stop bits, STOP2 dropped mid-frame");
        baud_val  = '0;
        bit8      = 1'b1;
        parity_en = 1'b0;
        stop2     = 1'b1;
        sb_push_frame(8'h01, 1'b1, 1'b0, 1'b0, 2);
        sb_push_frame(8'h01, 1'b1, 1'b0, 1'b0, 1);
        fifo_q.push_back(8'h01);
        fifo_q.push_back(8'h01);
        fork
            check_frames(2, 16, first_rdb, last_rdb);
            begin
                wait_rdb(5000, ok);
                repeat (40) @(negedge clk);
                stop2 = 1'b0;
            end
        join
        wait_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_8n1();
        test_7bit_parity();
        test_back_to_back();
        test_empty_in_stop();
        test_empty_stuck();
        test_reset_midframe();
`ifdef COREUART_TX_STOP2_EN
        test_stop2();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
